// File: rtl/arb_pkg.sv
// Shared types for the two-port unified-memory arbiter.
// The lock-length counter width is derived from LOCK_MAX.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } owner_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    localparam int LOCK_MAX_DEFAULT = 4;

    function automatic int lock_w(input int lock_max);
        return $clog2(lock_max + 1);
    endfunction

    localparam int LOCK_W = lock_w(LOCK_MAX_DEFAULT);

endpackage

// File: rtl/arb_beat_counter.sv
// Saturating count of beats granted to the current owner.
// A clear has priority over an increment.
module arb_beat_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (core C, DMA D) in front of a single synchronous-read memory.
// Registered owner with round-robin tie break and a bounded lock length.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wd,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rd,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wd,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int CNT_W = lock_w(LOCK_MAX);

    owner_t        owner_q, owner_d;
    port_id_t      last_q, last_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] c_rd_q, c_rd_d;
    logic [DW-1:0] d_rd_q, d_rd_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wd_q, wd_d;

    logic at_max;
    logic cnt_clr;
    logic cnt_inc;
    logic c_own, d_own;
    logic c_gnt_w, d_gnt_w;

    arb_beat_counter #(
        .MAX (LOCK_MAX),
        .W   (CNT_W)
    ) u_beats (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    always_comb begin
        c_own = (owner_q == OWN_C);
        d_own = (owner_q == OWN_D);
        // At the lock limit with the other port waiting, this cycle is the switch bubble.
        c_gnt_w = c_own && c_req && !(at_max && d_req);
        d_gnt_w = d_own && d_req && !(at_max && c_req);

        owner_d = owner_q;
        last_d  = last_q;
        unique case (owner_q)
            IDLE: begin
                if (c_req && d_req) begin
                    owner_d = (last_q == PORT_D) ? OWN_C : OWN_D;
                end else if (c_req) begin
                    owner_d = OWN_C;
                end else if (d_req) begin
                    owner_d = OWN_D;
                end
            end
            OWN_C: begin
                if (!c_req) begin
                    last_d  = PORT_C;
                    owner_d = d_req ? OWN_D : IDLE;
                end else if (at_max && d_req) begin
                    last_d  = PORT_C;
                    owner_d = OWN_D;
                end
            end
            OWN_D: begin
                if (!d_req) begin
                    last_d  = PORT_D;
                    owner_d = c_req ? OWN_C : IDLE;
                end else if (at_max && c_req) begin
                    last_d  = PORT_D;
                    owner_d = OWN_C;
                end
            end
            default: owner_d = IDLE;
        endcase

        cnt_clr = (owner_d != owner_q) && (owner_d != IDLE);
        cnt_inc = c_gnt_w || d_gnt_w;

        // Address and write data follow the owner while it requests, else hold.
        adr_d = adr_q;
        wd_d  = wd_q;
        if (c_own && c_req) begin
            adr_d = c_adr;
            wd_d  = c_wd;
        end else if (d_own && d_req) begin
            adr_d = d_adr;
            wd_d  = d_wd;
        end

        c_rvalid_d = c_gnt_w && !c_we;
        d_rvalid_d = d_gnt_w && !d_we;
        c_rd_d     = c_rvalid_q ? mem_rd : c_rd_q;
        d_rd_d     = d_rvalid_q ? mem_rd : d_rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= IDLE;
            last_q     <= PORT_D;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rd_q     <= '0;
            d_rd_q     <= '0;
            adr_q      <= '0;
            wd_q       <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rd_q     <= c_rd_d;
            d_rd_q     <= d_rd_d;
            adr_q      <= adr_d;
            wd_q       <= wd_d;
        end
    end

    assign c_gnt    = c_gnt_w;
    assign d_gnt    = d_gnt_w;
    assign mem_we   = (c_gnt_w && c_we) || (d_gnt_w && d_we);
    assign mem_adr  = adr_d;
    assign mem_wd   = wd_d;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rd     = c_rd_d;
    assign d_rd     = d_rd_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural arbitration model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LM = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] c_adr = '0, d_adr = '0;
    logic [DW-1:0] c_wd = '0, d_wd = '0;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
    logic [DW-1:0] c_rd, d_rd, mem_wd, mem_rd;
    logic [AW-1:0] mem_adr;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rd(c_rd),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rd(d_rd),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Synchronous-read memory, 256 words, word-addressed by adr[9:2].
    logic [DW-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem_rd = '0;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_adr[9:2]] <= mem_wd;
            mem_rd <= mem[mem_adr[9:2]];
        end
    end

    // Behavioural model: who holds the memory, how many beats it has used this tenure,
    // who was released last, pending read data per port and a reference memory image.
    logic [DW-1:0] ref_mem [0:255];
    int            m_own, m_last, m_beats, c_wait, d_wait;
    logic          m_crv, m_drv, egc, egd;
    logic [DW-1:0] m_cdat, m_ddat, m_crd, m_drd, m_wd;
    logic [AW-1:0] m_adr;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + i;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_own = 0; m_last = 2; m_beats = 0; c_wait = 0; d_wait = 0;
                m_crv = 0; m_drv = 0; m_crd = '0; m_drd = '0; m_adr = '0; m_wd = '0;
                chk("rst_ctl", {27'd0, c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we}, 32'd0);
                chk("rst_adr", mem_adr, 32'd0);
                chk("rst_wd", mem_wd, 32'd0);
                chk("rst_crd", c_rd, 32'd0);
                chk("rst_drd", d_rd, 32'd0);
            end else begin
                egc = (m_own == 1) && c_req && !(m_beats >= LM && d_req);
                egd = (m_own == 2) && d_req && !(m_beats >= LM && c_req);
                chk("c_gnt", c_gnt, egc);
                chk("d_gnt", d_gnt, egd);
                chk("excl", c_gnt & d_gnt, 0);
                if (m_own == 1 && c_req) begin
                    m_adr = c_adr; m_wd = c_wd;
                end else if (m_own == 2 && d_req) begin
                    m_adr = d_adr; m_wd = d_wd;
                end
                chk("mem_we", mem_we, (egc && c_we) || (egd && d_we));
                chk("mem_adr", mem_adr, m_adr);
                chk("mem_wd", mem_wd, m_wd);
                if (m_crv) m_crd = m_cdat;
                if (m_drv) m_drd = m_ddat;
                chk("c_rvalid", c_rvalid, m_crv);
                chk("d_rvalid", d_rvalid, m_drv);
                chk("c_rd", c_rd, m_crd);
                chk("d_rd", d_rd, m_drd);
                m_crv = egc && !c_we;
                m_drv = egd && !d_we;
                if (egc) begin
                    if (c_we) ref_mem[c_adr[9:2]] = c_wd;
                    else m_cdat = ref_mem[c_adr[9:2]];
                end
                if (egd) begin
                    if (d_we) ref_mem[d_adr[9:2]] = d_wd;
                    else m_ddat = ref_mem[d_adr[9:2]];
                end
                if (c_gnt) begin
                    chk("c_wait", c_wait <= LM + 2, 1);
                    c_wait = 0;
                end else c_wait = c_req ? c_wait + 1 : 0;
                if (d_gnt) begin
                    chk("d_wait", d_wait <= LM + 2, 1);
                    d_wait = 0;
                end else d_wait = d_req ? d_wait + 1 : 0;
                // Ownership bookkeeping for the next cycle.
                if (m_own == 0) begin
                    if (c_req && d_req) m_own = (m_last == 2) ? 1 : 2;
                    else if (c_req) m_own = 1;
                    else if (d_req) m_own = 2;
                    m_beats = 0;
                end else begin
                    logic mine, other;
                    mine  = (m_own == 1) ? c_req : d_req;
                    other = (m_own == 1) ? d_req : c_req;
                    if (!mine || (m_beats >= LM && other)) begin
                        m_last  = m_own;
                        m_own   = other ? 3 - m_own : 0;
                        m_beats = 0;
                    end else if (m_beats < LM) begin
                        m_beats++;
                    end
                end
            end
        end
    end

    logic          cg, dg, crv, mwe;
    logic [DW-1:0] crd;

    task automatic cyc();
        @(negedge clk);
        cg = c_gnt; dg = d_gnt; crv = c_rvalid; crd = c_rd; mwe = mem_we;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        c_req = 0; d_req = 0; c_we = 0; d_we = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    logic [11:0]   sc, sd;
    logic [5:0]    sg, sv;
    logic [DW-1:0] rdv [0:7];
    int            nrd, wecnt, first;
    logic [DW-1:0] got;

    initial begin
        // C-only reads of 0x0, 0x4, 0x8.
        do_reset();
        c_req = 1; c_we = 0; c_adr = 32'h0; sg = '0; sv = '0; nrd = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            sg[k] = cg; sv[k] = crv;
            if (crv && nrd < 8) begin rdv[nrd] = crd; nrd++; end
            if (cg) begin
                if (c_adr == 32'h8) c_req = 0;
                else c_adr = c_adr + 4;
            end
        end
        chk("t1_gnt_seq", {26'd0, sg}, 32'b001110);
        chk("t1_rv_seq", {26'd0, sv}, 32'b011100);
        chk("t1_rd0", rdv[0], 32'h1000_0000);
        chk("t1_rd1", rdv[1], 32'h1000_0001);
        chk("t1_rd2", rdv[2], 32'h1000_0002);

        // Both requesting continuously from IDLE.
        do_reset();
        c_req = 1; d_req = 1; c_adr = 32'h40; d_adr = 32'h80; sc = '0; sd = '0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            sc[k] = cg; sd[k] = dg;
            if (cg) c_adr = c_adr + 4;
            if (dg) d_adr = d_adr + 4;
        end
        chk("t2_c_seq", {20'd0, sc}, 32'h81E);
        chk("t2_d_seq", {20'd0, sd}, 32'h3C0);

        // D writes 0xDEADBEEF to 0x100, then C reads it back.
        do_reset();
        d_req = 1; d_we = 1; d_adr = 32'h100; d_wd = 32'hDEADBEEF; wecnt = 0; got = '0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (mwe) wecnt++;
            if (crv) got = crd;
            if (cg) c_req = 0;
            if (dg) begin
                d_req = 0; d_we = 0; c_req = 1; c_we = 0; c_adr = 32'h100;
            end
        end
        chk("t3_we_cnt", wecnt, 1);
        chk("t3_rd", got, 32'hDEADBEEF);

        // C drops after 2 beats while D waits; D then gets a full lock.
        do_reset();
        c_req = 1; d_req = 1; c_adr = 32'h20; d_adr = 32'h30; sc = '0; sd = '0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            sc[k] = cg; sd[k] = dg;
            if (k == 2) c_req = 0;
            if (k == 3) c_req = 1;
        end
        chk("t4_c_seq", {20'd0, sc}, 32'h206);
        chk("t4_d_seq", {20'd0, sd}, 32'h0F0);

        // Reset right after a granted C read drops the read return.
        do_reset();
        d_req = 0; c_req = 1; c_we = 0; c_adr = 32'h10;
        cyc();
        cyc();
        chk("t5_gnt", cg, 1);
        reset = 0; c_req = 0;
        cyc();
        chk("t5_rv", crv, 0);
        chk("t5_gnt0", cg, 0);
        chk("t5_crd", crd, 32'd0);
        cyc();
        reset = 1; c_req = 1; d_req = 1; first = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (first == 0) begin
                if (cg) first = 1;
                else if (dg) first = 2;
            end
        end
        chk("t5_first", first, 1);

        // Random traffic; each requester holds until granted.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            cyc();
            if (!c_req || cg) begin
                c_req = ($urandom_range(0, 3) != 0);
                c_we  = ($urandom_range(0, 2) == 0);
                c_adr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                c_wd  = $urandom;
            end
            if (!d_req || dg) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_we  = ($urandom_range(0, 2) == 0);
                d_adr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                d_wd  = $urandom;
            end
        end
        c_req = 0; d_req = 0;
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
